// File: rtl/mips32_pkg.sv
// Types and constants shared by the mips32 front end.
// The fetch stage and its prefetch FIFO both use fetch_entry_t.
package mips32_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Prefetch FIFO of {inst, pc} entries with a single-cycle flush.
// Whatever entry is at the head is always readable on o_head.
module inst_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  fetch_entry_t       i_entry,
    input  logic               i_pop,
    output fetch_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && !o_empty;

    // NOTE: sequential state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // NOTE: storage has no reset; r_count decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order responses
// tagged with their request PC, prefetch buffering and redirect flushing.
module fetch_unit
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      r_fetch_pc;
    logic             r_req_valid;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic [31:0]      r_tag_q [DEPTH];
    logic [PTR_W-1:0] r_tag_wr;
    logic [PTR_W-1:0] r_tag_rd;

    logic             w_accept;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_outstanding_next;
    logic [CNT_W-1:0] w_discard_next;
    logic [CNT_W:0]   w_credit_used;
    logic             w_req_valid_next;
    logic [31:0]      w_fetch_pc_next;
    fetch_entry_t     w_head;
    fetch_entry_t     w_rsp_entry;

    assign w_accept = r_req_valid && imem_req_ready;
    // A response with nothing in flight can only be stale, so it is ignored.
    assign w_rsp    = imem_rsp_valid && (r_outstanding != '0);
    assign w_push   = w_rsp && (r_discard == '0) && !redirect_valid;
    assign w_pop    = inst_valid && inst_ready;

    assign w_rsp_entry = '{inst: imem_rsp_data, pc: r_tag_q[r_tag_rd]};

    assign w_outstanding_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
    assign w_count_next       = redirect_valid ? '0
                              : w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_credit_used      = {1'b0, w_count_next} + {1'b0, w_outstanding_next};
    assign w_req_valid_next   = (w_credit_used < (CNT_W + 1)'(DEPTH));

    assign w_fetch_pc_next = redirect_valid ? align_pc(redirect_pc)
                           : w_accept       ? r_fetch_pc + PC_INC
                           : r_fetch_pc;

    // NOTE: default first so every path assigns the signal and no latch is inferred.
    always_comb begin
        w_discard_next = r_discard;
        if (redirect_valid) begin
            w_discard_next = w_outstanding_next;
        end else if (w_rsp && (r_discard != '0)) begin
            w_discard_next = r_discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_next;
            r_req_valid   <= w_req_valid_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            if (w_accept) r_tag_wr <= r_tag_wr + PTR_W'(1);
            if (w_rsp)    r_tag_rd <= r_tag_rd + PTR_W'(1);
        end
    end

    // Tags are never flushed: discarded responses still retire their entry.
    always_ff @(posedge clk) begin
        if (w_accept) r_tag_q[r_tag_wr] <= r_fetch_pc;
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_entry (w_rsp_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = !w_empty;
    assign inst           = w_empty ? '0 : w_head.inst;
    assign inst_pc        = w_empty ? '0 : w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with fixed latency,
// delivery log, and hand-computed expected PC/instruction streams.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus controls, applied by step() at the falling edge.
    int          lat;
    int          cyc = 0;
    int          n_rsp;
    logic        tb_ready;
    logic        tb_redirect;
    logic [31:0] tb_redirect_pc;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_cyc[$];
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_inst[$];
    logic [31:0] deliv_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    function automatic int count_in(input logic [31:0] q[$], input logic [31:0] lo,
                                    input logic [31:0] hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
        return n;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        inst_ready     = tb_ready;
        redirect_valid = tb_redirect;
        redirect_pc    = tb_redirect_pc;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            pend_due.delete(0);
            pend_addr.delete(0);
            n_rsp++;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            acc_addr.push_back(imem_req_addr);
            acc_cyc.push_back(cyc);
        end
        if (inst_valid && inst_ready) begin
            deliv_pc.push_back(inst_pc);
            deliv_inst.push_back(inst);
            deliv_cyc.push_back(cyc);
        end
        // A full FIFO must never coexist with requests still in flight.
        if (dut.w_count == DEPTH) check("full_no_inflight", 64'(dut.r_outstanding), 0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        tb_redirect = 1'b0;
        repeat (5) step();
        pend_addr.delete();
        pend_due.delete();
        acc_addr.delete();
        acc_cyc.delete();
        deliv_pc.delete();
        deliv_inst.delete();
        deliv_cyc.delete();
        n_rsp          = 0;
        imem_rsp_valid = 1'b0;
        rst            = 1'b0;
    endtask

    task automatic redirect_step(input logic [31:0] target);
        tb_redirect    = 1'b1;
        tb_redirect_pc = target;
        step();
        tb_redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        int   mark;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        tb_ready       = 1'b1;
        tb_redirect    = 1'b0;
        tb_redirect_pc = '0;
        lat            = 1;
        n_rsp          = 0;

        // Reset state
        repeat (3) step();
        check("rst_req_valid",  imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst",       inst, 0);
        check("rst_inst_pc",    inst_pc, 0);

        // 1: single-cycle memory, free-running consumer
        do_reset();
        repeat (12) step();
        check("t1_acc0", qget(acc_addr, 0), 32'h0);
        check("t1_acc1", qget(acc_addr, 1), 32'h4);
        check("t1_first_latency", qget(deliv_cyc, 0) - qget(acc_cyc, 0), 2);
        for (int i = 0; i < 6; i++) begin
            check("t1_pc",   qget(deliv_pc, i),   32'(4 * i));
            check("t1_inst", qget(deliv_inst, i), 32'(4 * i) ^ 32'hA5A5_0000);
        end
        check("t1_throughput", qget(deliv_cyc, 5) - qget(deliv_cyc, 0), 5);

        // 2: stalled consumer exhausts credits
        do_reset();
        tb_ready = 1'b0;
        repeat (20) step();
        check("t2_num_req",     acc_addr.size(), DEPTH);
        check("t2_req_valid",   imem_req_valid, 0);
        check("t2_head_valid",  inst_valid, 1);
        check("t2_head_pc",     inst_pc, 32'h0);
        tb_ready = 1'b1;
        repeat (12) step();
        check("t2_pc0", qget(deliv_pc, 0), 32'h0);
        check("t2_pc1", qget(deliv_pc, 1), 32'h4);
        check("t2_pc2", qget(deliv_pc, 2), 32'h8);
        check("t2_pc3", qget(deliv_pc, 3), 32'hC);
        check("t2_pc4", qget(deliv_pc, 4), 32'h10);
        check("t2_resume_addr", qget(acc_addr, 4), 32'h10);

        // 3: latency 3, redirect with three requests in flight
        do_reset();
        lat = 3;
        for (int k = 0; k < 20 && acc_addr.size() < 2; k++) step();
        redirect_step(32'h0000_0103);
        check("t3_inflight", acc_addr.size(), 3);
        repeat (20) step();
        check("t3_pc0",   qget(deliv_pc, 0),   32'h100);
        check("t3_inst0", qget(deliv_inst, 0), 32'hA5A5_0100);
        check("t3_pc1",   qget(deliv_pc, 1),   32'h104);
        check("t3_pc2",   qget(deliv_pc, 2),   32'h108);
        check("t3_no_old", count_in(deliv_pc, 32'h0, 32'h100), 0);

        // 4: back-to-back redirects, later one wins
        do_reset();
        lat = 1;
        repeat (6) step();
        check("t4_busy_before", inst_valid, 1);
        redirect_step(32'h0000_0200);
        redirect_step(32'h0000_0300);
        check("t4_flushed", inst_valid, 0);
        mark = deliv_pc.size();
        repeat (10) step();
        check("t4_pc0", qget(deliv_pc, mark),     32'h300);
        check("t4_pc1", qget(deliv_pc, mark + 1), 32'h304);
        check("t4_no_200", count_in(deliv_pc, 32'h200, 32'h300), 0);

        // 5: fetch address wraps at the top of the address space
        do_reset();
        repeat (4) step();
        redirect_step(32'hFFFF_FFF8);
        mark = deliv_pc.size();
        repeat (10) step();
        check("t5_pc0",   qget(deliv_pc, mark),       32'hFFFF_FFF8);
        check("t5_inst0", qget(deliv_inst, mark),     32'h5A5A_FFF8);
        check("t5_pc1",   qget(deliv_pc, mark + 1),   32'hFFFF_FFFC);
        check("t5_inst1", qget(deliv_inst, mark + 1), 32'h5A5A_FFFC);
        check("t5_pc2",   qget(deliv_pc, mark + 2),   32'h0);
        check("t5_inst2", qget(deliv_inst, mark + 2), 32'hA5A5_0000);

        // 6: asynchronous reset mid-stream
        do_reset();
        lat   = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (inst_valid && (acc_addr.size() - n_rsp) >= 2) found = 1'b1;
        end
        check("t6_found_busy", found, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_req_valid",  imem_req_valid, 0);
        check("t6_inst_valid", inst_valid, 0);
        check("t6_inst",       inst, 0);
        check("t6_inst_pc",    inst_pc, 0);
        do_reset();
        repeat (12) step();
        check("t6_acc0",   qget(acc_addr, 0),   32'h0);
        check("t6_pc0",    qget(deliv_pc, 0),   32'h0);
        check("t6_inst0",  qget(deliv_inst, 0), 32'hA5A5_0000);
        check("t6_pc1",    qget(deliv_pc, 1),   32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the mips32 single-cycle datapath.
- Generates sequential PCs and issues requests to an instruction memory with variable latency.
- Buffers returned words in a small prefetch FIFO and hands {inst, pc} to decode/execute over a valid/ready handshake.
- Accepts branch/jump redirects from the datapath, flushing queued and in-flight fetches.

Parameters:
DEPTH, 4, prefetch FIFO entries; also the maximum number of outstanding plus buffered fetches (power of 2, ≥2).
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch byte address, word aligned.
imem_req_ready  input  1  memory accepts request this cycle.
imem_rsp_valid  input  1  response word valid; responses return in request order.
imem_rsp_data  input  32  instruction word.
redirect_valid  input  1  taken branch/jump from datapath, single-cycle pulse.
redirect_pc  input  32  new fetch target; bits [1:0] ignored.
inst_valid  output  1  FIFO head valid.
inst  output  32  FIFO head instruction.
inst_pc  output  32  byte address of inst.
inst_ready  input  1  consumer takes head this cycle.

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0; imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- Reset deassertion: first request is issued no earlier than the next rising edge.
- Credit rule: imem_req_valid=1 iff (count + outstanding) < DEPTH and not rst.
  - Registered decision, independent of imem_req_ready and redirect_valid.
  - imem_req_addr = fetch_pc.
- Request accept (valid & ready):
  - fetch_pc += 4, with 32-bit wrap FFFF_FFFC→0000_0000.
  - outstanding += 1.
  - Tag FIFO of request PCs: pc travels with the request; a DEPTH-entry PC queue inside the block is allowed.
- Response:
  - outstanding -= 1.
  - If discard>0: word dropped, discard -= 1.
  - Else: {data, pc} pushed to FIFO. Push never overflows, guaranteed by the credit rule.
- Output: inst_valid = FIFO not empty; inst/inst_pc driven from the head. Pop on inst_valid & inst_ready.
- Redirect (redirect_valid=1 at edge):
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - FIFO flushed: count=0, next-cycle inst_valid=0.
  - discard = outstanding_next, i.e. all in-flight requests including one accepted this same cycle.
  - A response arriving in the redirect cycle is dropped and is not counted into discard.
  - A pop in the redirect cycle is a completed transfer; the consumer owns that instruction.
- Back-to-back redirects: the later one wins; discard is recomputed from the current outstanding count.
- Simultaneous push and pop with FIFO full: legal only when count=DEPTH and outstanding=0, so no push can occur; the bench checks this as an assertion.
- Throughput: with single-cycle memory and inst_ready=1, one instruction per cycle in steady state. First inst_valid appears 2 cycles after the first request accept.
- Counter widths: outstanding and discard are $clog2(DEPTH+1) bits and never exceed DEPTH.
- Mid-operation reset returns all state to reset values immediately; memory responses during reset are ignored.

Decomposition:
- Shared package mips32_pkg holds:
  - INST_W=32, PC_INC=4, DEFAULT_RESET_PC.
  - Packed struct fetch_entry_t {inst[31:0], pc[31:0]}.
- One natural sub-module: inst_fifo, a synchronous DEPTH-entry FIFO of fetch_entry_t.
  - Flush input; count output; async active-high rst.
- Credit, discard and PC logic stay in fetch_unit.

Test Plan:
- Reset then idle memory (ready=1, 1-cycle rsp, mem[a]=a^32'hA5A5_0000), inst_ready=1 → inst/pc stream: pc 0,4,8,… with inst=pc^A5A5_0000, one per cycle after 2-cycle start.
- inst_ready=0 for 20 cycles → exactly DEPTH=4 requests issued, then imem_req_valid=0. Release → pcs 0,4,8,C delivered in order, fetching resumes at 10.
- Memory latency 3 cycles, redirect_pc=32'h0000_0103 while 3 requests in flight → 3 responses dropped; next delivered inst_pc=0000_0100; no old pc reaches the output.
- Redirect pulses on two consecutive cycles (0x200 then 0x300) → first delivered inst_pc=0x300; 0x200 is never delivered.
- Redirect to 32'hFFFF_FFF8 → delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst asynchronously mid-stream with 2 outstanding → outputs zero within the same cycle; after release, fetch restarts at RESET_PC; late responses are not delivered.
